// File: rtl/memhub_arb_if.sv
// Channel-side and SDRAM-command-side signal bundle for memhub_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface memhub_arb_if #(
   parameter int NCH = 4,
   parameter int AW  = 26,
   parameter int DW  = 16
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   // Handshake: a channel holds a nonzero ch_req slice (with mask/addr/wdata
   // stable) until it sees its one-cycle ch_ack; cmd_req stays stable until
   // the controller answers with cmd_ack; sd_data_valid is steered to the
   // channel of the most recently acknowledged command.
   logic [2*NCH-1:0]  ch_req;
   logic [2*NCH-1:0]  ch_mask;
   logic [AW*NCH-1:0] ch_addr;
   logic [DW*NCH-1:0] ch_wdata;
   logic [NCH-1:0]    ch_ack;
   logic [NCH-1:0]    ch_data_valid;
   logic [1:0]        cmd_req;
   logic [1:0]        cmd_mask;
   logic [AW-1:0]     cmd_addr;
   logic [DW-1:0]     cmd_din;
   logic              cmd_ack;
   logic              sd_data_valid;
   logic [IW-1:0]     grant_ch;

   modport slave (
      input  ch_req, ch_mask, ch_addr, ch_wdata, cmd_ack, sd_data_valid,
      output ch_ack, ch_data_valid, cmd_req, cmd_mask, cmd_addr, cmd_din,
             grant_ch
   );

   modport master (
      output ch_req, ch_mask, ch_addr, ch_wdata, cmd_ack, sd_data_valid,
      input  ch_ack, ch_data_valid, cmd_req, cmd_mask, cmd_addr, cmd_din,
             grant_ch
   );
endinterface

// File: rtl/memhub_arb.sv
// N-channel request manager in front of the SDRAM controller command port.
// Define MEMHUB_RR_EN for round-robin arbitration; otherwise fixed priority.
module memhub_arb #(
   parameter int NCH = 4,
   parameter int AW  = 26,
   parameter int DW  = 16
) (
   input  logic        clk,
   input  logic        reset,
   memhub_arb_if.slave bus,
   output logic [1:0]  state_dbg
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAITACK = 2'd1,
      S_END     = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   data_owner;
   logic [NCH-1:0]  req_vec;
   logic [IW-1:0]   win;
   logic [1:0]      sel_req;
   logic [1:0]      sel_mask;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

`ifdef MEMHUB_RR_EN
   logic [IW-1:0]   rr_ptr;
`endif

   assign state_dbg = state;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         req_vec[i] = |bus.ch_req[2*i +: 2];
      end
   end

`ifdef MEMHUB_RR_EN
   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      logic found;
      int   idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(rr_ptr) + k) % NCH;
         for (int i = 0; i < NCH; i++) begin
            if (!found && (idx == i) && req_vec[i]) begin
               win   = IW'(i);
               found = 1'b1;
            end
         end
      end
   end
`else
   always_comb begin
      win = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (req_vec[i]) win = IW'(i);
      end
   end
`endif

   always_comb begin
      sel_req  = '0;
      sel_mask = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (win == IW'(i)) begin
            sel_req  = bus.ch_req[2*i +: 2];
            sel_mask = bus.ch_mask[2*i +: 2];
            sel_addr = bus.ch_addr[AW*i +: AW];
            sel_data = bus.ch_wdata[DW*i +: DW];
         end
      end
   end

   // Read data belongs to whoever was acknowledged last, not the current grant.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         bus.ch_data_valid[i] = bus.sd_data_valid && (data_owner == IW'(i));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         bus.cmd_req  <= '0;
         bus.cmd_mask <= '0;
         bus.cmd_addr <= '0;
         bus.cmd_din  <= '0;
         bus.ch_ack   <= '0;
         bus.grant_ch <= '0;
         data_owner   <= '0;
`ifdef MEMHUB_RR_EN
         rr_ptr       <= IW'(NCH - 1);
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (|req_vec) begin
                  bus.cmd_req  <= sel_req;
                  bus.cmd_mask <= sel_mask;
                  // Line fetches are issued line-aligned.
                  bus.cmd_addr <= {sel_addr[AW-1:3],
                                   sel_req[0] ? sel_addr[2:0] : 3'b000};
                  bus.cmd_din  <= sel_data;
                  bus.grant_ch <= win;
`ifdef MEMHUB_RR_EN
                  rr_ptr       <= win;
`endif
                  state        <= S_WAITACK;
               end
            end
            S_WAITACK: begin
               if (bus.cmd_ack) begin
                  bus.cmd_req <= '0;
                  bus.ch_ack  <= NCH'(1) << bus.grant_ch;
                  data_owner  <= bus.grant_ch;
                  state       <= S_END;
               end
            end
            S_END: begin
               bus.ch_ack <= '0;
               state      <= S_IDLE;
            end
            default: begin
               bus.ch_ack <= '0;
               state      <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_memhub_arb.sv
// Directed bench for memhub_arb: grant/ack timing, address alignment,
// read-data steering, asynchronous reset and arbitration order.
module tb_memhub_arb;
   localparam int NCH = 4;
   localparam int AW  = 26;
   localparam int DW  = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state_dbg;
   int         total = 0;
   int         bad   = 0;
   logic [1:0] exp_q[$];
   logic [1:0] exp_g;

   memhub_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

   memhub_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [1:0] r, input logic [AW-1:0] a,
                         input logic [1:0] m, input logic [DW-1:0] d);
      bus.ch_req[2*ch +: 2]    = r;
      bus.ch_mask[2*ch +: 2]   = m;
      bus.ch_addr[AW*ch +: AW] = a;
      bus.ch_wdata[DW*ch +: DW] = d;
   endtask

   task automatic pulse_ack();
      bus.cmd_ack = 1'b1;
      @(negedge clk);
      bus.cmd_ack = 1'b0;
   endtask

   // One grant/ack round with requests held; starts at a negedge in IDLE.
   task automatic grant_round(input string tag, input logic [1:0] g);
      @(negedge clk);
      chk({tag, "_grant"}, 64'(bus.grant_ch), 64'(g));
      chk({tag, "_cmdreq"}, 64'(bus.cmd_req), 64'(2'b01));
      chk({tag, "_addr"}, 64'(bus.cmd_addr), 64'(26'h100 + g));
      @(negedge clk);
      pulse_ack();
      chk({tag, "_ack"}, 64'(bus.ch_ack), 64'(4'b0001 << g));
      @(negedge clk);
      chk({tag, "_ackoff"}, 64'(bus.ch_ack), 64'(0));
      chk({tag, "_idle"}, 64'(state_dbg), 64'(0));
   endtask

   initial begin
      reset             = 1'b0;
      bus.ch_req        = '0;
      bus.ch_mask       = '0;
      bus.ch_addr       = '0;
      bus.ch_wdata      = '0;
      bus.cmd_ack       = 1'b0;
      bus.sd_data_valid = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_cmdreq", 64'(bus.cmd_req), 64'(0));
      chk("rst_ack", 64'(bus.ch_ack), 64'(0));
      chk("rst_grant", 64'(bus.grant_ch), 64'(0));
      chk("rst_state", 64'(state_dbg), 64'(0));
      chk("rst_addr", 64'(bus.cmd_addr), 64'(0));
      chk("rst_dv_owner0", 64'(bus.ch_data_valid), 64'(4'b0001));
      bus.sd_data_valid = 1'b0;
      reset = 1'b1;

      // Word access on channel 1.
      set_ch(1, 2'b01, 26'h0000005, 2'b10, 16'hBEEF);
      @(negedge clk);
      chk("w1_cmdreq", 64'(bus.cmd_req), 64'(2'b01));
      chk("w1_addr", 64'(bus.cmd_addr), 64'(26'h0000005));
      chk("w1_mask", 64'(bus.cmd_mask), 64'(2'b10));
      chk("w1_din", 64'(bus.cmd_din), 64'(16'hBEEF));
      chk("w1_grant", 64'(bus.grant_ch), 64'(1));
      chk("w1_state", 64'(state_dbg), 64'(1));
      bus.ch_req = '0;
      @(negedge clk);
      chk("w1_hold", 64'(bus.cmd_req), 64'(2'b01));
      pulse_ack();
      chk("w1_ack", 64'(bus.ch_ack), 64'(4'b0010));
      chk("w1_cmdreq_low", 64'(bus.cmd_req), 64'(0));
      @(negedge clk);
      chk("w1_ack_once", 64'(bus.ch_ack), 64'(0));
      chk("w1_idle", 64'(state_dbg), 64'(0));

      // Line fetch on channel 2: low address bits forced to zero.
      set_ch(2, 2'b10, 26'h3FFFFFF, 2'b11, 16'h1234);
      @(negedge clk);
      chk("lf_cmdreq", 64'(bus.cmd_req), 64'(2'b10));
      chk("lf_addr", 64'(bus.cmd_addr), 64'(26'h3FFFFF8));
      chk("lf_grant", 64'(bus.grant_ch), 64'(2));
      bus.ch_req = '0;
      pulse_ack();
      chk("lf_ack", 64'(bus.ch_ack), 64'(4'b0100));
      @(negedge clk);

      // Read on channel 3, then an un-acked grant to channel 1.
      set_ch(3, 2'b10, 26'h0001234, 2'b00, 16'h0000);
      @(negedge clk);
      chk("rd3_grant", 64'(bus.grant_ch), 64'(3));
      bus.ch_req = '0;
      pulse_ack();
      chk("rd3_ack", 64'(bus.ch_ack), 64'(4'b1000));
      @(negedge clk);
      set_ch(1, 2'b01, 26'h0000040, 2'b01, 16'h5555);
      @(negedge clk);
      chk("rd1_grant", 64'(bus.grant_ch), 64'(1));
      chk("rd1_state", 64'(state_dbg), 64'(1));
      bus.ch_req = '0;
      for (int p = 0; p < 3; p++) begin
         bus.sd_data_valid = 1'b1;
         #1;
         chk("dv_to3", 64'(bus.ch_data_valid), 64'(4'b1000));
         @(negedge clk);
         bus.sd_data_valid = 1'b0;
         #1;
         chk("dv_off", 64'(bus.ch_data_valid), 64'(0));
         @(negedge clk);
      end
      pulse_ack();
      chk("rd1_ack", 64'(bus.ch_ack), 64'(4'b0010));
      bus.sd_data_valid = 1'b1;
      #1;
      chk("dv_to1", 64'(bus.ch_data_valid), 64'(4'b0010));
      @(negedge clk);
      bus.sd_data_valid = 1'b0;

      // Reset during WAITACK with cmd_ack present.
      set_ch(2, 2'b01, 26'h0000077, 2'b11, 16'hAAAA);
      @(negedge clk);
      chk("rw_state", 64'(state_dbg), 64'(1));
      chk("rw_cmdreq", 64'(bus.cmd_req), 64'(2'b01));
      bus.ch_req  = '0;
      bus.cmd_ack = 1'b1;
      reset       = 1'b0;
      #1;
      chk("rw_cmdreq0", 64'(bus.cmd_req), 64'(0));
      chk("rw_ack0", 64'(bus.ch_ack), 64'(0));
      chk("rw_grant0", 64'(bus.grant_ch), 64'(0));
      chk("rw_state0", 64'(state_dbg), 64'(0));
      @(negedge clk);
      chk("rw_ack_held0", 64'(bus.ch_ack), 64'(0));
      bus.cmd_ack = 1'b0;
      reset       = 1'b1;

      // All four channels requesting continuously.
      for (int c = 0; c < NCH; c++) set_ch(c, 2'b01, 26'h100 + c, 2'b11, 16'(c));
`ifdef MEMHUB_RR_EN
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      while (exp_q.size() > 0) begin
         exp_g = exp_q.pop_front();
         grant_round("all", exp_g);
      end

      // Channels 1 and 3 hold their requests past ch_ack.
      bus.ch_req = '0;
      set_ch(1, 2'b01, 26'h101, 2'b11, 16'h0001);
      set_ch(3, 2'b01, 26'h103, 2'b11, 16'h0003);
`ifdef MEMHUB_RR_EN
      exp_q = '{2'd1, 2'd3, 2'd1};
`else
      exp_q = '{2'd1, 2'd1, 2'd1};
`endif
      while (exp_q.size() > 0) begin
         exp_g = exp_q.pop_front();
         grant_round("hold", exp_g);
      end
      bus.ch_req = '0;
      @(negedge clk);
      @(negedge clk);
      chk("final_idle", 64'(state_dbg), 64'(0));
      chk("final_cmdreq", 64'(bus.cmd_req), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/memhub_arb.md
# memhub_arb

Parametrised N-channel request manager sitting between the per-bus cache front-ends and the SDRAM controller command port. Each channel posts a 2-bit command with mask, address and write data. The block grants one channel at a time, drives the controller command port, and returns a one-cycle acknowledge to the winner. Read-data-valid is then steered to the channel that owns the outstanding access. Arbitration is round-robin across NCH channels, or fixed priority when round-robin is compiled out.

## Interface
Parameters:
- NCH, 4, number of master channels (2..8); IW = $clog2(NCH)
- AW, 26, address width
- DW, 16, data width

Ports:
- reset  in  1  reset, asynchronous, active-low
- clk  in  1  clock clk
- ch_req  in  2*NCH  per-channel command, bits [2i+1:2i]; 0 = idle, nonzero = request; bit0 = 1 word access, bit0 = 0 line fetch
- ch_mask  in  2*NCH  per-channel byte mask
- ch_addr  in  AW*NCH  per-channel address
- ch_wdata  in  DW*NCH  per-channel write data
- ch_ack  out  NCH  one-cycle acknowledge, one-hot
- ch_data_valid  out  NCH  steered read-data-valid
- cmd_req  out  2  command to SDRAM controller
- cmd_mask  out  2  latched mask
- cmd_addr  out  AW  latched address
- cmd_din  out  DW  latched write data
- cmd_ack  in  1  controller accepted command
- sd_data_valid  in  1  controller read-data-valid
- grant_ch  out  IW  index of the last granted channel

## Operation
- FSM states: IDLE, WAITACK, END; reset state IDLE.
- IDLE:
  - If any ch_req slice is nonzero, select a winner w and latch ch_req[w], ch_mask[w], ch_addr[w] and ch_wdata[w] into cmd_*. Set grant_ch = w and go to WAITACK.
  - cmd_addr[AW-1:3] takes the channel address. cmd_addr[2:0] takes the channel address when cmd_req[0] = 1, otherwise 3'b0 (line-aligned).
- WAITACK:
  - Hold cmd_* stable.
  - On cmd_ack: cmd_req <= 0, ch_ack[grant_ch] <= 1, data_owner <= grant_ch; go to END.
- END: ch_ack <= 0; go to IDLE.
- ch_data_valid[i] = sd_data_valid && (data_owner == i), combinational.
- data_owner changes only on cmd_ack. A read issued before a new grant is therefore still steered correctly until the next acknowledge.
- Illegal state encodings go to IDLE.
- Reset values: state IDLE; cmd_req 0; cmd_mask 0; cmd_addr 0; cmd_din 0; ch_ack 0; grant_ch 0; data_owner 0; rr pointer NCH-1.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous). A pending cmd_ack is discarded and no ch_ack is produced.

## Timing
- Request visible at IDLE sampling edge k -> cmd_req valid after edge k (latency 1).
- cmd_ack sampled at edge m -> ch_ack high from edge m to edge m+1 and cmd_req low after edge m.
- Earliest next grant is sampled at edge m+2.
- A channel must drop ch_req by the edge ending its ch_ack cycle (m+1). Otherwise it is re-granted at m+2.
- ch_req changes while the block is in WAITACK or END are ignored. Only IDLE samples requests.
- Back-to-back throughput is one command per 3 cycles plus the controller ack latency.
- ch_data_valid has zero-cycle latency from sd_data_valid.

## Configuration
- MEMHUB_RR_EN defined:
  - Round-robin arbitration. The search starts at rr+1 modulo NCH; the first requesting channel wins, and rr <= w on grant.
  - With all channels requesting continuously, grants rotate 0,1,...,NCH-1,0.
- MEMHUB_RR_EN undefined:
  - Fixed priority; the lowest index wins.
  - The rr register is absent. A continuously requesting channel 0 starves all others.

## Test plan
- Reset, then single request ch_req[3:2] = 2'b01 (word access), ch_addr[1] = 0x0000_5 -> cmd_req = 01 and cmd_addr = 0x0000005 one cycle later. After cmd_ack, ch_ack = 4'b0010 for exactly 1 cycle.
- Line fetch on channel 2, ch_req = 2'b10, addr = 0x3FFFFFF -> cmd_addr = 0x3FFFFF8.
- All 4 channels requesting continuously, cmd_ack 2 cycles after each cmd_req:
  - With MEMHUB_RR_EN, the grant order is 0,1,2,3,0.
  - Without it, the grant order is 0,0,0.
- Grant channel 3 read, then pulse sd_data_valid 3 times -> only ch_data_valid[3] pulses. A subsequent grant to channel 1 that has not yet been acked still steers to channel 3.
- Assert reset during WAITACK with cmd_ack high in the same cycle -> cmd_req = 0 and ch_ack = 0 immediately. After release, state is IDLE and the first grant goes to channel 0.
- Requester keeps ch_req high past ch_ack -> the same channel is re-granted at edge m+2 (fixed priority) or after the other requesting channels (round-robin).
